// File: rtl/ahb3lite_arbiter.sv
// Round-robin address-phase arbiter for several AHB3-Lite masters sharing one slave port.
// Tracks address-phase (gnt) and data-phase (dgnt) ownership; never switches inside a burst or lock.
module ahb3lite_arbiter #(
  parameter  int MASTERS  = 3,
  localparam int MID_SIZE = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                   HRESETn,
  input  logic                   HCLK,
  input  logic [MASTERS-1:0]     req_HSEL,
  input  logic [2*MASTERS-1:0]   req_HTRANS,
  input  logic [MASTERS-1:0]     req_HMASTLOCK,
  input  logic                   HREADY,
  output logic [MASTERS-1:0]     gnt,
  output logic [MID_SIZE-1:0]    gnt_id,
  output logic [MASTERS-1:0]     dgnt,
  output logic [MID_SIZE-1:0]    dgnt_id,
  output logic                   locked
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  logic [MASTERS-1:0]  request;
  logic [1:0]          owner_trans;
  logic                owner_sel;
  logic                owner_lock;
  logic                hold;
  logic                data_valid;
  logic [MID_SIZE-1:0] arb_id;
  logic [MID_SIZE-1:0] next_id;
  logic [MASTERS-1:0]  arb_gnt;
  logic                next_lock;

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      request[i] = req_HSEL[i] & (req_HTRANS[2*i +: 2] == HTRANS_NONSEQ);
    end
  end

  // Owner's bus signals, selected from the registered id rather than the one-hot vector
  always_comb begin
    owner_trans = HTRANS_IDLE;
    owner_sel   = 1'b0;
    owner_lock  = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      if (gnt_id == MID_SIZE'(i)) begin
        owner_trans = req_HTRANS[2*i +: 2];
        owner_sel   = req_HSEL[i];
        owner_lock  = req_HMASTLOCK[i];
      end
    end
  end

  assign hold = (owner_sel & ((owner_trans == HTRANS_SEQ) | (owner_trans == HTRANS_BUSY)))
              | owner_lock;

  assign data_valid = owner_sel & ((owner_trans == HTRANS_NONSEQ) | (owner_trans == HTRANS_SEQ));

  // Scan owner+1 .. owner (wrapping); the current owner is seen last, so it parks when alone
  always_comb begin : arb_scan
    logic found;
    int   idx;
    arb_id = gnt_id;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = int'(gnt_id) + k;
      if (idx >= MASTERS) idx = idx - MASTERS;
      if (!found && request[idx]) begin
        arb_id = MID_SIZE'(idx);
        found  = 1'b1;
      end
    end
  end

  assign next_id = hold ? gnt_id : arb_id;

  always_comb begin
    arb_gnt   = '0;
    next_lock = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      if (arb_id == MID_SIZE'(i)) arb_gnt[i] = 1'b1;
      if (next_id == MID_SIZE'(i)) next_lock = req_HMASTLOCK[i];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt     <= {{(MASTERS-1){1'b0}}, 1'b1};
      gnt_id  <= '0;
      dgnt    <= '0;
      dgnt_id <= '0;
      locked  <= 1'b0;
    end else if (HREADY) begin
      if (!hold) begin
        gnt    <= arb_gnt;
        gnt_id <= arb_id;
      end
      locked <= next_lock;
      if (data_valid) begin
        dgnt    <= gnt;
        dgnt_id <= gnt_id;
      end else begin
        dgnt    <= '0;
        dgnt_id <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_arbiter.sv
// Bench for ahb3lite_arbiter: vector table of per-cycle inputs with hand-derived ownership,
// driven through an expectation queue, plus rotation and asynchronous-reset sequences.
module tb_ahb3lite_arbiter;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;

  typedef struct {
    logic [2:0] hsel;
    logic [5:0] htrans;
    logic [2:0] lock;
    logic       hready;
    logic [2:0] exp_gnt;
    logic [2:0] exp_dgnt;
    logic       exp_locked;
  } vec_t;

  logic       HRESETn;
  logic       HCLK;
  logic [2:0] req_HSEL;
  logic [5:0] req_HTRANS;
  logic [2:0] req_HMASTLOCK;
  logic       HREADY;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic [2:0] dgnt;
  logic [1:0] dgnt_id;
  logic       locked;

  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  ahb3lite_arbiter #(.MASTERS(3)) dut (
    .HRESETn       (HRESETn),
    .HCLK          (HCLK),
    .req_HSEL      (req_HSEL),
    .req_HTRANS    (req_HTRANS),
    .req_HMASTLOCK (req_HMASTLOCK),
    .HREADY        (HREADY),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .dgnt          (dgnt),
    .dgnt_id       (dgnt_id),
    .locked        (locked)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [1:0] oh2id(input logic [2:0] oh);
    for (int i = 0; i < 3; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %0h expected %0h", name, step_no, act, exp);
    end
  endtask

  function automatic void add(input logic [2:0] hsel, input logic [1:0] t2, input logic [1:0] t1,
                              input logic [1:0] t0, input logic [2:0] lock, input logic hr,
                              input logic [2:0] eg, input logic [2:0] ed, input logic el);
    vec_t v;
    v.hsel = hsel; v.htrans = {t2, t1, t0}; v.lock = lock; v.hready = hr;
    v.exp_gnt = eg; v.exp_dgnt = ed; v.exp_locked = el;
    vecs.push_back(v);
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    req_HSEL      = v.hsel;
    req_HTRANS    = v.htrans;
    req_HMASTLOCK = v.lock;
    HREADY        = v.hready;
    exp_q.push_back(v);
    @(posedge HCLK);
    #1;
    e = exp_q.pop_front();
    check("gnt",     32'(gnt),     32'(e.exp_gnt));
    check("gnt_id",  32'(gnt_id),  32'(oh2id(e.exp_gnt)));
    check("dgnt",    32'(dgnt),    32'(e.exp_dgnt));
    check("dgnt_id", 32'(dgnt_id), 32'(oh2id(e.exp_dgnt)));
    check("locked",  32'(locked),  32'(e.exp_locked));
    step_no++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_gnt"},     32'(gnt),     32'h1);
    check({tag, "_gnt_id"},  32'(gnt_id),  32'h0);
    check({tag, "_dgnt"},    32'(dgnt),    32'h0);
    check({tag, "_dgnt_id"}, 32'(dgnt_id), 32'h0);
    check({tag, "_locked"},  32'(locked),  32'h0);
  endtask

  initial begin
    vec_t v;
    HRESETn = 1'b0; req_HSEL = '0; req_HTRANS = '0; req_HMASTLOCK = '0; HREADY = 1'b1;

    // Two masters request together, then owner hands over as requests retire
    add(3'b110, N, N, I, 3'b000, 1, 3'b010, 3'b000, 0);
    add(3'b110, N, N, I, 3'b000, 1, 3'b100, 3'b010, 0);
    add(3'b101, N, I, N, 3'b000, 1, 3'b001, 3'b100, 0);
    add(3'b001, I, I, N, 3'b000, 1, 3'b001, 3'b001, 0);
    add(3'b000, I, I, I, 3'b000, 1, 3'b001, 3'b000, 0);
    // Master 1 INCR4 with wait states while master 2 requests
    add(3'b010, I, N, I, 3'b000, 1, 3'b010, 3'b000, 0);
    add(3'b010, I, N, I, 3'b000, 1, 3'b010, 3'b010, 0);
    add(3'b110, N, S, I, 3'b000, 1, 3'b010, 3'b010, 0);
    add(3'b110, N, S, I, 3'b000, 0, 3'b010, 3'b010, 0);
    add(3'b110, N, S, I, 3'b000, 0, 3'b010, 3'b010, 0);
    add(3'b110, N, S, I, 3'b000, 1, 3'b010, 3'b010, 0);
    add(3'b110, N, S, I, 3'b000, 1, 3'b010, 3'b010, 0);
    add(3'b100, N, I, I, 3'b000, 1, 3'b100, 3'b000, 0);
    add(3'b100, N, I, I, 3'b000, 1, 3'b100, 3'b100, 0);
    add(3'b000, I, I, I, 3'b000, 1, 3'b100, 3'b000, 0);
    // Master 0 locked for five transfers against two competitors
    add(3'b001, I, I, N, 3'b001, 1, 3'b001, 3'b000, 1);
    for (int k = 0; k < 5; k++) add(3'b111, N, N, N, 3'b001, 1, 3'b001, 3'b001, 1);
    add(3'b110, N, N, I, 3'b000, 1, 3'b010, 3'b000, 0);
    add(3'b110, N, N, I, 3'b000, 1, 3'b100, 3'b010, 0);
    add(3'b100, N, I, I, 3'b000, 1, 3'b100, 3'b100, 0);
    add(3'b000, I, I, I, 3'b000, 1, 3'b100, 3'b000, 0);
    // Data phase frozen by wait states, then BUSY and unselect handling
    add(3'b100, N, I, I, 3'b000, 1, 3'b100, 3'b100, 0);
    for (int k = 0; k < 3; k++) add(3'b100, N, I, I, 3'b000, 0, 3'b100, 3'b100, 0);
    add(3'b000, I, I, I, 3'b000, 1, 3'b100, 3'b000, 0);
    add(3'b101, B, I, N, 3'b000, 1, 3'b100, 3'b000, 0);
    add(3'b101, S, I, N, 3'b000, 1, 3'b100, 3'b100, 0);
    add(3'b001, I, I, N, 3'b000, 1, 3'b001, 3'b000, 0);
    add(3'b001, I, I, N, 3'b000, 1, 3'b001, 3'b001, 0);
    add(3'b000, I, I, I, 3'b000, 1, 3'b001, 3'b000, 0);

    repeat (2) @(posedge HCLK);
    #1;
    check_reset_state("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // All three request continuously: grant rotates 1,2,0,... and dgnt trails by one
    for (int k = 0; k < 9; k++) begin
      v.hsel = 3'b111; v.htrans = {N, N, N}; v.lock = 3'b000; v.hready = 1'b1;
      v.exp_gnt    = 3'(1 << ((k + 1) % 3));
      v.exp_dgnt   = 3'(1 << (k % 3));
      v.exp_locked = 1'b0;
      step(v);
    end

    // Reset asserted in the middle of a burst acts without a clock edge
    v.hsel = 3'b010; v.htrans = {I, N, I}; v.lock = 3'b000; v.hready = 1'b1;
    v.exp_gnt = 3'b010; v.exp_dgnt = 3'b000; v.exp_locked = 1'b0;
    step(v);
    v.exp_dgnt = 3'b010;
    step(v);
    v.htrans = {I, S, I};
    step(v);
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge HCLK);
    HRESETn = 1'b1;
    v.hsel = 3'b000; v.htrans = {I, I, I};
    v.exp_gnt = 3'b001; v.exp_dgnt = 3'b000;
    step(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb3lite_arbiter.md
# ahb3lite_arbiter

Round-robin address-phase arbiter that lets several AHB3-Lite masters share one downstream AHB3-Lite slave port, typically the asynchronous AHB-to-APB bridge. It tracks address-phase ownership (`gnt`) and data-phase ownership (`dgnt`), and never rearbitrates inside a burst or a locked sequence. The surrounding interconnect uses `gnt_id`/`dgnt_id` as mux selects and stalls non-granted masters. Entirely synchronous to HCLK.

## Interface
- MASTERS, 3: number of requesting masters, 2..8.
- MID_SIZE, $clog2(MASTERS): width of the id outputs (localparam, minimum 1).
- HRESETn  in  1  reset; asynchronous, active-low.
- HCLK  in  1  clock.
- req_HSEL  in  MASTERS  per-master slave select.
- req_HTRANS  in  2*MASTERS  per-master HTRANS; master i at bits [2i+1:2i].
- req_HMASTLOCK  in  MASTERS  per-master lock.
- HREADY  in  1  slave-side HREADYOUT (the bridge's), i.e. transfer-complete qualifier.
- gnt  out  MASTERS  one-hot address-phase owner.
- gnt_id  out  MID_SIZE  binary index of gnt.
- dgnt  out  MASTERS  one-hot data-phase owner; all zero when no data phase is active.
- dgnt_id  out  MID_SIZE  binary index of dgnt; 0 when dgnt is zero.
- locked  out  1  owner is in a locked sequence.

## Operation
- Request of master i: `req_HSEL[i] & (HTRANS_i == NONSEQ)`.
- Hold condition on owner o: `req_HSEL[o] & HTRANS_o ∈ {SEQ, BUSY}`, or `req_HMASTLOCK[o]`. While hold is true, `gnt` is frozen.
- Arbitration occurs only on a cycle with HREADY=1 and hold false.
  - Next owner is the first requesting master scanning o+1, o+2, …, MASTERS-1, 0, …, o (wrapping).
  - The current owner is therefore lowest priority among requesters.
- If nothing requests, `gnt` parks on the current owner (no change).
- `locked` is registered on every HREADY=1 edge as `req_HMASTLOCK[next owner]`. It holds otherwise.
- Data phase, on every HREADY=1 edge:
  - `dgnt <= gnt` if the owner presents `req_HSEL & HTRANS ∈ {NONSEQ, SEQ}`.
  - Otherwise (IDLE/BUSY/unselected), `dgnt <= 0`.
  - With HREADY=0, `dgnt` holds.
- `gnt_id`/`dgnt_id` are registered alongside their one-hot vectors, never decoded combinationally from them.
- `gnt` is always exactly one-hot. `dgnt` is one-hot or zero.
- Reset values: `gnt=1` (master 0 parked), `gnt_id=0`, `dgnt=0`, `dgnt_id=0`, `locked=0`.
- Reset mid-burst: all state returns to reset values immediately. No pending grant survives.

## Timing
- Grant latency is 1 cycle. A request sampled with HREADY=1 and no hold at edge N makes `gnt` valid after edge N.
  - The newly granted master's address phase is sampled by the slave at edge N+1.
- HREADY=0 freezes `gnt`, `gnt_id`, `dgnt`, `dgnt_id` and `locked`. Wait states never change ownership.
- `dgnt` lags `gnt` by exactly one HREADY=1 edge, matching the AHB pipeline.
- Simultaneous requests: one winner per arbitration cycle per the rotation. Losers keep requesting and win on later arbitration cycles, in rotation order.
- A burst holds ownership from NONSEQ through the last SEQ.
  - Rearbitration happens on the first HREADY=1 cycle where the owner shows IDLE or NONSEQ, or deasserts HSEL.
- A locked sequence holds ownership until `req_HMASTLOCK[o]` drops. Arbitration happens in that same cycle if HREADY=1.
- A BUSY from the owner holds `gnt` and zeroes `dgnt` at the next HREADY=1 edge.

## Test plan
- Reset → `gnt=001`, `gnt_id=0`, `dgnt=000`, `locked=0`. Assert HRESETn mid-burst → same values asynchronously.
- Masters 1 and 2 issue NONSEQ together, owner 0 idle, HREADY=1 → `gnt=010` next cycle. After master 1 goes IDLE → `gnt=100`. Then master 0 NONSEQ → `gnt=001`.
- Owner 1 runs INCR4 (NONSEQ, SEQ×3) with master 2 requesting and HREADY low for 2 cycles mid-burst → `gnt` stays `010` throughout. `gnt=100` one cycle after master 1 goes IDLE.
- Owner 0 holds HMASTLOCK=1 for 5 transfers while masters 1 and 2 request → `gnt=001` and `locked=1` until lock drops. Then `gnt=010` and `locked=0`.
- Owner 2 issues NONSEQ with HREADY=0 for 3 cycles → `dgnt=100` and `dgnt_id=2` held. After a final IDLE with HREADY=1 → `dgnt=000`.
- All three masters request continuously with single NONSEQ transfers → grant order 1, 2, 0, 1, 2, 0, …; no master waits more than 2 arbitration cycles.
